// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, LCR word-length codes
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [4:0] {
    S_TX_IDLE  = 5'b00001,
    S_TX_START = 5'b00010,
    S_TX_DATA  = 5'b00100,
    S_TX_PAR   = 5'b01000,
    S_TX_STOP  = 5'b10000
  } uart_tx_fsm_state_e;

  localparam logic [1:0] UART_WLEN_5 = 2'b00;
  localparam logic [1:0] UART_WLEN_6 = 2'b01;
  localparam logic [1:0] UART_WLEN_7 = 2'b10;
  localparam logic [1:0] UART_WLEN_8 = 2'b11;

  // Parity over the valid data bits only; stick parity overrides the data.
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic [1:0] wlen,
                                       input logic       eps,
                                       input logic       sps);
    logic [7:0] mask;
    logic       x;
    unique case (wlen)
      UART_WLEN_5: mask = 8'h1F;
      UART_WLEN_6: mask = 8'h3F;
      UART_WLEN_7: mask = 8'h7F;
      default:     mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (sps)      return ~eps;
    else if (eps) return x;
    else          return ~x;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serial transmitter: start, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Define UART_TX_CTS_EN to add CTS flow control.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned OS_RATE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_tx_en_i,
  input  logic       bclk_tick_i,
  input  logic [1:0] lcr_wlen_i,
  input  logic       lcr_pen_i,
  input  logic       lcr_eps_i,
  input  logic       lcr_sps_i,
  input  logic       lcr_stp2_i,
  input  logic       lcr_brk_i,
  input  logic [7:0] uart_tx_data_i,
  input  logic       uart_tx_valid_i,
`ifdef UART_TX_CTS_EN
  input  logic       uart_cts_ni,
`endif
  output logic       uart_tx_ready_o,
  output logic       uart_tx_busy_o,
  output logic       uart_tx_done_o,
  output logic       uart_tx_o
);

  localparam int unsigned TW = $clog2(OS_RATE);

  uart_tx_fsm_state_e state_q, state_d;

  logic [TW-1:0] tick_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [1:0]    wlen_q;
  logic          pen_q;
  logic          par_q;
  logic          stp2_lat_q;
  logic          stp2_q;
  logic          tx_q;
  logic          done_q;
  logic          line_d;
  logic          cts_ok;
  logic          accept;
  logic          bit_end;
  logic          last_data;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cts_sync_q <= 2'b11;
    else       cts_sync_q <= {cts_sync_q[0], uart_cts_ni};
  end

  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign uart_tx_ready_o = (state_q == S_TX_IDLE) && uart_tx_en_i && cts_ok;
  assign uart_tx_busy_o  = (state_q != S_TX_IDLE);
  assign uart_tx_done_o  = done_q;
  assign uart_tx_o       = tx_q;

  assign accept    = uart_tx_valid_i && uart_tx_ready_o;
  assign bit_end   = bclk_tick_i && (tick_cnt_q == TW'(OS_RATE - 1));
  assign last_data = (bit_cnt_q == (3'd4 + {1'b0, wlen_q}));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_TX_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: each combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TX_IDLE:  if (accept)  state_d = S_TX_START;
      S_TX_START: if (bit_end) state_d = S_TX_DATA;
      S_TX_DATA:  if (bit_end && last_data) state_d = pen_q ? S_TX_PAR : S_TX_STOP;
      S_TX_PAR:   if (bit_end) state_d = S_TX_STOP;
      S_TX_STOP:  if (bit_end && (!stp2_lat_q || stp2_q)) state_d = S_TX_IDLE;
      default:    state_d = S_TX_IDLE;
    endcase
  end

  // Break overrides the line ahead of the output flop; framing carries on.
  always_comb begin
    line_d = 1'b1;
    unique case (state_q)
      S_TX_START: line_d = 1'b0;
      S_TX_DATA:  line_d = shift_q[0];
      S_TX_PAR:   line_d = par_q;
      default:    line_d = 1'b1;
    endcase
    if (lcr_brk_i) line_d = 1'b0;
  end

  // NOTE: the frame shadow registers are reset too; they are few, and a
  // defined value keeps the datapath deterministic straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wlen_q     <= UART_WLEN_8;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
      stp2_lat_q <= 1'b0;
      stp2_q     <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      tx_q   <= line_d;
      done_q <= (state_q == S_TX_STOP) && (state_d == S_TX_IDLE);
      if (accept) begin
        tick_cnt_q <= '0;
        bit_cnt_q  <= '0;
        shift_q    <= uart_tx_data_i;
        wlen_q     <= lcr_wlen_i;
        pen_q      <= lcr_pen_i;
        par_q      <= uart_parity(uart_tx_data_i, lcr_wlen_i, lcr_eps_i, lcr_sps_i);
        stp2_lat_q <= lcr_stp2_i;
        stp2_q     <= 1'b0;
      end else if (state_q != S_TX_IDLE && bclk_tick_i) begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
        if (bit_end && state_q == S_TX_DATA) begin
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (bit_end && state_q == S_TX_STOP && stp2_lat_q) stp2_q <= ~stp2_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: each frame is ticked by hand, every line slot
// is sampled mid-bit against a hand-written bit pattern.
module tb_uart_tx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       uart_tx_en_i;
  logic       bclk_tick_i;
  logic [1:0] lcr_wlen_i;
  logic       lcr_pen_i;
  logic       lcr_eps_i;
  logic       lcr_sps_i;
  logic       lcr_stp2_i;
  logic       lcr_brk_i;
  logic [7:0] uart_tx_data_i;
  logic       uart_tx_valid_i;
  logic       uart_tx_ready_o;
  logic       uart_tx_busy_o;
  logic       uart_tx_done_o;
  logic       uart_tx_o;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  uart_tx #(.OS_RATE(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .uart_tx_en_i    (uart_tx_en_i),
    .bclk_tick_i     (bclk_tick_i),
    .lcr_wlen_i      (lcr_wlen_i),
    .lcr_pen_i       (lcr_pen_i),
    .lcr_eps_i       (lcr_eps_i),
    .lcr_sps_i       (lcr_sps_i),
    .lcr_stp2_i      (lcr_stp2_i),
    .lcr_brk_i       (lcr_brk_i),
    .uart_tx_data_i  (uart_tx_data_i),
    .uart_tx_valid_i (uart_tx_valid_i),
`ifdef UART_TX_CTS_EN
    .uart_cts_ni     (1'b0),
`endif
    .uart_tx_ready_o (uart_tx_ready_o),
    .uart_tx_busy_o  (uart_tx_busy_o),
    .uart_tx_done_o  (uart_tx_done_o),
    .uart_tx_o       (uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (uart_tx_done_o === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One baud tick per call step, launched and removed on falling edges.
  task automatic tick_n(input int n);
    repeat (n) begin
      bclk_tick_i = 1'b1;
      @(negedge clk_i);
      bclk_tick_i = 1'b0;
    end
  endtask

  task automatic set_fmt(input logic [1:0] wl, input logic p, input logic e,
                         input logic s, input logic st2);
    lcr_wlen_i = wl;
    lcr_pen_i  = p;
    lcr_eps_i  = e;
    lcr_sps_i  = s;
    lcr_stp2_i = st2;
  endtask

  // Handshake one character; returns once the start bit is on the line.
  task automatic start_frame(input logic [7:0] d, input string tag);
    uart_tx_data_i  = d;
    uart_tx_valid_i = 1'b1;
    @(negedge clk_i);
    uart_tx_valid_i = 1'b0;
    check({tag, " busy"}, 16'(uart_tx_busy_o), 16'h1);
    @(negedge clk_i);
    check({tag, " start"}, 16'(uart_tx_o), 16'h0);
  endtask

  // Slot i of exp is the expected line level for the i-th 16-tick bit;
  // done must rise exactly on the last tick of the last slot.
  task automatic check_frame(input logic [15:0] exp, input int nbits, input string tag);
    for (int i = 0; i < nbits; i++) begin
      tick_n(8);
      check($sformatf("%s bit%0d", tag, i), 16'(uart_tx_o), 16'(exp[i]));
      if (i < nbits - 1) begin
        tick_n(8);
      end else begin
        tick_n(7);
        check({tag, " done early"}, 16'(uart_tx_done_o), 16'h0);
        tick_n(1);
        check({tag, " done"}, 16'(uart_tx_done_o), 16'h1);
      end
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    uart_tx_en_i    = 1'b1;
    bclk_tick_i     = 1'b0;
    lcr_brk_i       = 1'b0;
    uart_tx_data_i  = 8'h00;
    uart_tx_valid_i = 1'b0;
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk_i);
    check("rst line", 16'(uart_tx_o), 16'h1);
    check("rst busy", 16'(uart_tx_busy_o), 16'h0);
    check("rst done", 16'(uart_tx_done_o), 16'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle ready", 16'(uart_tx_ready_o), 16'h1);
    check("idle line", 16'(uart_tx_o), 16'h1);

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1 -> 160 ticks
    start_frame(8'h55, "8n1");
    check_frame(16'h02AA, 10, "8n1");
    @(negedge clk_i);
    check("8n1 done pulse", 16'(uart_tx_done_o), 16'h0);
    check("8n1 idle busy", 16'(uart_tx_busy_o), 16'h0);
    check("8n1 done count", 16'(done_cnt), 16'h1);

    // 7E1 0x41: data 1,0,0,0,0,0,1, even parity 0
    set_fmt(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    start_frame(8'h41, "7e1");
    check_frame(16'h0282, 10, "7e1");
    @(negedge clk_i);

    // 7 bits, stick parity with eps=0 -> parity 1
    set_fmt(2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    start_frame(8'h41, "7s1");
    check_frame(16'h0382, 10, "7s1");
    @(negedge clk_i);

    // 5O2 0xFF: data 11111, odd parity 0, two stops -> 144 ticks;
    // LCR switched to 8N1 after acceptance must not touch this frame
    set_fmt(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    start_frame(8'hFF, "5o2");
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame(16'h01BE, 9, "5o2");
    @(negedge clk_i);

    // Back-to-back: 0xA5 8N1, then 0x3C picked up with wlen changed to 5
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    uart_tx_data_i  = 8'hA5;
    uart_tx_valid_i = 1'b1;
    @(negedge clk_i);
    check("b2b busy", 16'(uart_tx_busy_o), 16'h1);
    uart_tx_data_i = 8'h3C;
    lcr_wlen_i     = 2'b00;
    @(negedge clk_i);
    check("b2b start1", 16'(uart_tx_o), 16'h0);
    check_frame(16'h034A, 10, "b2b1");
    check("b2b ready", 16'(uart_tx_ready_o), 16'h1);
    @(negedge clk_i);
    uart_tx_valid_i = 1'b0;
    check("b2b accept2", 16'(uart_tx_busy_o), 16'h1);
    check("b2b gap line", 16'(uart_tx_o), 16'h1);
    @(negedge clk_i);
    check("b2b start2", 16'(uart_tx_o), 16'h0);
    check_frame(16'h0078, 7, "b2b2");
    @(negedge clk_i);

    // No ticks: line and state hold; then break mid-frame
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(8'hFF, "hold");
    tick_n(8);
    repeat (40) @(negedge clk_i);
    check("hold line", 16'(uart_tx_o), 16'h0);
    check("hold busy", 16'(uart_tx_busy_o), 16'h1);
    tick_n(16);
    check("pre brk line", 16'(uart_tx_o), 16'h1);
    lcr_brk_i = 1'b1;
    @(negedge clk_i);
    check("brk line", 16'(uart_tx_o), 16'h0);
    tick_n(16);
    check("brk held", 16'(uart_tx_o), 16'h0);
    lcr_brk_i = 1'b0;
    @(negedge clk_i);
    check("brk release", 16'(uart_tx_o), 16'h1);
    tick_n(119);
    check("brk done early", 16'(uart_tx_done_o), 16'h0);
    tick_n(1);
    check("brk done", 16'(uart_tx_done_o), 16'h1);
    @(negedge clk_i);

    // Reset mid-frame: line returns high without waiting for a clock edge
    start_frame(8'h00, "rstmid");
    tick_n(20);
    check("rstmid busy", 16'(uart_tx_busy_o), 16'h1);
    check("rstmid low", 16'(uart_tx_o), 16'h0);
    #2 rst_i = 1'b1;
    #1;
    check("rstmid line", 16'(uart_tx_o), 16'h1);
    check("rstmid idle", 16'(uart_tx_busy_o), 16'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstmid ready", 16'(uart_tx_ready_o), 16'h1);
    check("rstmid line2", 16'(uart_tx_o), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
